// File: rtl/gate_checker_pkg.sv
// Shared types, truth-table constants and helpers for the two-input gate self-test engine.
package gate_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Vector index {x1,x0}; also the bit position inside a truth table.
  typedef logic [1:0] vec_idx_t;

  // Truth tables, bit index = {x1,x0}.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  // Returns tt with entry idx replaced by val.
  function automatic logic [3:0] tt_set(input logic [3:0] tt, input vec_idx_t idx,
                                        input logic val);
    logic [3:0] r;
    r      = tt;
    r[idx] = val;
    return r;
  endfunction

endpackage

// File: rtl/gate_checker_sync2.sv
// Generic two-flop synchroniser for signals arriving asynchronously to clk.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gate_checker.sv
// Sweeps all four {x1,x0} vectors onto a gate under test, captures z0 after a
// settling window per vector, and compares the captured truth table to EXPECTED.
module gate_checker
  import gate_checker_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [3:0]  EXPECTED      = TT_AND
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       z0,
  output logic       x0,
  output logic       x1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] captured,
  output logic [3:0] fail_vec
);

  localparam int unsigned      CNT_W    = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state;
  state_e           state_nxt;
  vec_idx_t         idx;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       vec_q;
  logic             z_sync;
  logic             settle_end;
  logic             last_vec;
  logic [3:0]       captured_nxt;

  sync2 #(.WIDTH(1)) u_z0_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (z0),
    .q    (z_sync)
  );

  assign x0 = vec_q[0];
  assign x1 = vec_q[1];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and capture strobe.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    state_nxt    = state;
    settle_end   = 1'b0;
    last_vec     = (idx == 2'd3);
    captured_nxt = captured;
    case (state)
      IDLE: begin
        if (start) state_nxt = DRIVE;
      end
      DRIVE: begin
        if (cnt == CNT_LAST) begin
          settle_end   = 1'b1;
          captured_nxt = tt_set(captured, idx, z_sync);
          if (last_vec) state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: vector index, settle counter, stimulus, capture and verdict.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx      <= 2'd0;
      cnt      <= '0;
      vec_q    <= 2'b00;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      captured <= 4'b0000;
      fail_vec <= 4'b0000;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx      <= 2'd0;
            cnt      <= '0;
            vec_q    <= 2'b00;
            pass     <= 1'b0;
            captured <= 4'b0000;
            fail_vec <= 4'b0000;
          end
        end
        DRIVE: begin
          captured <= captured_nxt;
          if (settle_end) begin
            cnt <= '0;
            if (last_vec) begin
              // Verdict is registered together with the final capture so it is
              // valid in the same cycle that done is high.
              vec_q    <= 2'b00;
              done     <= 1'b1;
              pass     <= (captured_nxt == EXPECTED);
              fail_vec <= captured_nxt ^ EXPECTED;
            end else begin
              idx   <= idx + 2'd1;
              vec_q <= idx + 2'd1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          vec_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_checker.sv
// Self-checking bench for gate_checker: table-driven sweeps over several gates,
// plus hand-written sequences for ignored start, mid-sweep reset and back-to-back runs.
module tb_gate_checker;
  import gate_checker_pkg::*;

  localparam int S_A = 4;
  localparam int S_B = 3;

  typedef struct {
    logic [3:0] gate;
    logic [3:0] captured;
    logic       pass;
    logic [3:0] fail_vec;
  } exp_t;

  logic       clk;
  logic       rstn;
  logic       start_a, start_b;
  logic       z0_a, z0_b;
  logic       x0_a, x1_a, x0_b, x1_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [3:0] captured_a, fail_vec_a, captured_b, fail_vec_b;
  logic [3:0] gate_tt;

  int   checks = 0;
  int   failures = 0;
  int   done_cnt_a = 0;
  exp_t vec_tbl[6];
  exp_t sb_a[$];
  exp_t sb_b[$];

  // Behavioural gates under test.
  assign z0_a = gate_tt[{x1_a, x0_a}];
  assign z0_b = x1_b ^ x0_b;

  gate_checker #(.SETTLE_CYCLES(S_A), .EXPECTED(TT_AND)) dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .z0(z0_a), .x0(x0_a), .x1(x1_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .captured(captured_a), .fail_vec(fail_vec_a)
  );

  gate_checker #(.SETTLE_CYCLES(S_B), .EXPECTED(TT_XOR)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .z0(z0_b), .x0(x0_b), .x1(x1_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .captured(captured_b), .fail_vec(fail_vec_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_result(input string tag, input exp_t e, input logic [3:0] cap,
                                input logic ps, input logic [3:0] fv);
    check({tag, ".captured"}, 32'(cap), 32'(e.captured));
    check({tag, ".pass"},     32'(ps),  32'(e.pass));
    check({tag, ".fail_vec"}, 32'(fv),  32'(e.fail_vec));
  endtask

  // One sweep on dut_a. Cycle c is observed at the falling edge after rising edge c-1.
  task automatic sweep_a(input exp_t e, input bit detail, input bit inject);
    bit   seen;
    exp_t got;
    seen    = 1'b0;
    gate_tt = e.gate;
    sb_a.push_back(e);
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= 4 * S_A + 10; c++) begin
      @(negedge clk);
      if (detail) begin
        check("a.busy", 32'(busy_a), 1);
        if (c <= 4 * S_A) check("a.vector", 32'({x1_a, x0_a}), (c - 1) / S_A);
      end
      start_a = inject && (c == 5 || c == 4 * S_A + 1);
      if (done_a === 1'b1) begin
        seen = 1'b1;
        check("a.done_cycle", c, 4 * S_A + 1);
        check("a.vector_in_done", 32'({x1_a, x0_a}), 0);
        check("a.sb_depth", sb_a.size(), 1);
        if (sb_a.size() > 0) begin
          got = sb_a.pop_front();
          compare_result("a", got, captured_a, pass_a, fail_vec_a);
        end
        break;
      end
    end
    check("a.done_seen", 32'(seen), 1);
  endtask

  initial begin
    int   done_snap;
    int   n;
    exp_t got;

    vec_tbl[0] = '{TT_AND,  4'b1000, 1'b1, 4'b0000};
    vec_tbl[1] = '{TT_OR,   4'b1110, 1'b0, 4'b0110};
    vec_tbl[2] = '{4'b1111, 4'b1111, 1'b0, 4'b0111};
    vec_tbl[3] = '{TT_XOR,  4'b0110, 1'b0, 4'b1110};
    vec_tbl[4] = '{TT_NAND, 4'b0111, 1'b0, 4'b1111};
    vec_tbl[5] = '{4'b0000, 4'b0000, 1'b0, 4'b1000};

    rstn    = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    gate_tt = TT_AND;
    repeat (3) @(negedge clk);
    check("rst.x",        32'({x1_a, x0_a}), 0);
    check("rst.busy",     32'(busy_a), 0);
    check("rst.done",     32'(done_a), 0);
    check("rst.pass",     32'(pass_a), 0);
    check("rst.captured", 32'(captured_a), 0);
    check("rst.fail_vec", 32'(fail_vec_a), 0);
    check("rst.b_busy",   32'(busy_b), 0);
    check("rst.b_captured", 32'(captured_b), 0);
    rstn = 1'b1;

    // Table-driven sweeps, back to back (each start lands on cycle 4S+2 of the previous).
    for (int i = 0; i < 6; i++) sweep_a(vec_tbl[i], (i == 0), 1'b0);

    // start at cycles 5 and 4S+1 must be ignored.
    @(negedge clk);
    done_snap = done_cnt_a;
    sweep_a(vec_tbl[0], 1'b0, 1'b1);
    @(negedge clk);
    start_a = 1'b0;
    check("ign.busy_after_done", 32'(busy_a), 0);
    repeat (20) @(negedge clk);
    check("ign.busy_later", 32'(busy_a), 0);
    check("ign.done_pulses", done_cnt_a - done_snap, 1);

    // A later start is accepted normally.
    sweep_a(vec_tbl[1], 1'b1, 1'b0);

    // Reset asserted during cycle 9 aborts the sweep.
    @(negedge clk);
    gate_tt = 4'b1111;
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    check("abort.partial_captured", 32'(captured_a), 32'h3);
    check("abort.busy_before", 32'(busy_a), 1);
    done_snap = done_cnt_a;
    rstn = 1'b0;
    @(negedge clk);
    check("abort.busy",     32'(busy_a), 0);
    check("abort.x",        32'({x1_a, x0_a}), 0);
    check("abort.captured", 32'(captured_a), 0);
    check("abort.pass",     32'(pass_a), 0);
    check("abort.fail_vec", 32'(fail_vec_a), 0);
    rstn = 1'b1;
    repeat (4 * S_A + 8) @(negedge clk);
    check("abort.no_done", done_cnt_a - done_snap, 0);

    // Recovery after the aborted sweep.
    sweep_a(vec_tbl[0], 1'b0, 1'b0);

    // S=3, XOR expected, start held high: done at cycle 13 then every 14 cycles.
    for (int k = 0; k < 3; k++) sb_b.push_back('{TT_XOR, 4'b0110, 1'b1, 4'b0000});
    @(negedge clk);
    start_b = 1'b1;
    n = 0;
    for (int c = 1; c <= 60 && n < 3; c++) begin
      @(negedge clk);
      if (done_b === 1'b1) begin
        check("b.done_cycle", c, (4 * S_B + 1) + (4 * S_B + 2) * n);
        check("b.sb_depth", sb_b.size(), 3 - n);
        if (sb_b.size() > 0) begin
          got = sb_b.pop_front();
          compare_result("b", got, captured_b, pass_b, fail_vec_b);
        end
        n++;
      end
    end
    start_b = 1'b0;
    check("b.done_count", n, 3);

    check("a.sb_empty", sb_a.size(), 0);
    check("b.sb_empty", sb_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_checker.md
# gate_checker

Self-test engine for the two-input logic-gate designs on the IceZUM board. On a `start` pulse it drives all four input vectors (`{x1,x0}` = 00, 01, 10, 11) onto a gate under test, holds each vector for a settling window, and samples the gate's `z0`. It then compares the captured truth table against a parameterised expected table and reports pass/fail. It is the response-reading counterpart of a stimulus sweep, implemented in hardware so results can be shown on the board LEDs.

## Interface
- `SETTLE_CYCLES`, default 4: cycles each vector is held before sampling; legal range 3..255.
- `EXPECTED`, default 4'b1000: expected `z0` per vector, bit index = `{x1,x0}` (AND gate).
- `clk`  in  1  system clock, 12 MHz.
- `rstn`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `z0`  in  1  gate output; asynchronous to `clk`, so it is synchronised internally.
- `x0`  out  1  gate input bit 0.
- `x1`  out  1  gate input bit 1.
- `busy`  out  1  sweep in progress (DRIVE or DONE).
- `done`  out  1  one-cycle pulse when results become valid.
- `pass`  out  1  captured table equals `EXPECTED`; held until the next accepted `start`.
- `captured`  out  4  sampled `z0` per vector; bit index = `{x1,x0}`.
- `fail_vec`  out  4  `captured ^ EXPECTED`; held alongside `pass`.

## Operation
- Reset, `rstn`=0 at a rising edge: state IDLE. Outputs `x0`=`x1`=`busy`=`done`=`pass`=0, `captured`=`fail_vec`=4'b0000. Vector index, settle counter and synchroniser all clear to 0.
- FSM states: IDLE, DRIVE, DONE.
  - IDLE: if `start`=1, clear `captured`, `pass` and `fail_vec`, set index=0 and counter=0, go to DRIVE. Otherwise stay in IDLE.
  - DRIVE: `{x1,x0}` = index, and the counter increments each cycle.
    - When counter = `SETTLE_CYCLES`-1, write the synchronised `z0` into `captured[index]` and reset the counter to 0.
    - If index = 3, go to DONE. Otherwise increment index.
  - DONE: for one cycle, `done`=1. `pass` = (`captured` == `EXPECTED`) and `fail_vec` = `captured ^ EXPECTED` are registered on this same edge. Then go to IDLE.
- `x0`/`x1` are registered outputs. They return to 0 in IDLE and DONE.
- `z0` passes through a two-flop synchroniser. Because `SETTLE_CYCLES` ≥ 3, the sampled value reflects the current vector through the gate plus 2 sync cycles.
- `start` in DRIVE or DONE is ignored; there is no queuing. Holding `start` high continuously restarts a sweep on the cycle after DONE.
- A reset asserted mid-sweep aborts the sweep at the next edge. All outputs take their reset values and partial `captured` data is discarded.
- Index is 2 bits and never wraps, because the DRIVE exit occurs at 3. The counter width is $clog2(`SETTLE_CYCLES`).

## Timing
- Let cycle 0 be the edge where `start` is sampled in IDLE. Let S = `SETTLE_CYCLES`.
- Vector k is driven during cycles 1+k·S through (k+1)·S.
- `captured[k]` updates at the edge ending cycle (k+1)·S.
- `busy`=1 during cycles 1..4S+1.
- `done`=1, with `pass`/`fail_vec` valid, at cycle 4S+1. With S=4 this is cycle 17.
- The earliest next accepted `start` is at cycle 4S+2.
- A full sweep takes 4S+2 cycles. At 12 MHz with S=4 that is 1.5 µs.

## Structure
- Shared package/include `gate_checker_pkg`:
  - state encodings IDLE=2'd0, DRIVE=2'd1, DONE=2'd2;
  - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001.
- One sub-module, `sync2`: a generic two-flop synchroniser with synchronous active-low reset to 0, used for `z0`.
- The FSM, counter, index, capture register and compare logic live in `gate_checker`.

## Test plan
- Reset, then `start` pulse, with S=4 and a behavioural AND gate on x0/x1→z0:
  - `{x1,x0}` steps 00, 01, 10, 11 every 4 cycles;
  - `done` at cycle 17 with `captured`=1000, `pass`=1, `fail_vec`=0000.
- `EXPECTED`=TT_AND but an OR gate connected → `captured`=1110, `pass`=0, `fail_vec`=0110.
- `z0` tied to 1 → `captured`=1111, `pass`=0, `fail_vec`=0111.
- `start` pulsed again at cycles 5 and 17 of a sweep → both ignored:
  - exactly one `done` pulse is produced;
  - a new sweep begins only from a `start` at cycle ≥ 18.
- `rstn`=0 at cycle 9 of a sweep → at the next edge `busy`=0, `x0`=`x1`=0, `captured`=0000, `pass`=0, and no `done` pulse follows.
- S=3 with `EXPECTED`=TT_XOR and an XOR gate:
  - `done` at cycle 13 with `pass`=1;
  - `start` held high continuously gives back-to-back sweeps with `done` every 14 cycles.
